// File: rtl/bin2bcd_iter.sv
// bin2bcd_iter: sequential binary-to-BCD converter (double dabble), one
// operand bit per clock. Optional two's-complement input, sign and overflow
// flags, and a start/busy/done handshake. The result registers hold their
// value until the next done pulse.
module bin2bcd_iter #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      num,
    input  logic                  sign_en,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]          state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    mag_sr;
    logic [4*DIGITS-1:0] scratch;
    logic                pend_neg;
    logic                pend_ovf;

    logic                is_neg;
    logic [WIDTH-1:0]    mag_in;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] scratch_nxt;
    logic [WIDTH-1:0]    mag_nxt;
    logic                carry_out;

    // Operand magnitude: negate negative two's-complement inputs. The most
    // negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    always_comb begin
        is_neg = sign_en & num[WIDTH-1];
        mag_in = is_neg ? (~num + WIDTH'(1)) : num;
    end

    // Add 3 to every scratch digit that is 5 or more. All digits are adjusted in parallel.
    always_comb begin
        // NOTE: default the whole vector first so that no path leaves adj
        // unassigned; an unassigned path would infer a latch.
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // One shift step. The bit leaving the top digit is lost from the result
    // and marks an overflow.
    assign {carry_out, scratch_nxt} = {adj, mag_sr[WIDTH-1]};
    assign mag_nxt                  = {mag_sr[WIDTH-2:0], 1'b0};

    assign busy = (state == SHIFT);

    // Control FSM, shift datapath and result registers.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so that every
        // register samples values from before the edge, whatever the statement order.
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mag_sr   <= '0;
            scratch  <= '0;
            pend_neg <= 1'b0;
            pend_ovf <= 1'b0;
            bcd      <= '0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_sr   <= mag_in;
                        pend_neg <= is_neg;
                        pend_ovf <= 1'b0;
                        scratch  <= '0;
                        cnt      <= CW'(WIDTH);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch  <= scratch_nxt;
                    mag_sr   <= mag_nxt;
                    pend_ovf <= pend_ovf | carry_out;
                    cnt      <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd   <= scratch_nxt;
                        neg   <= pend_neg;
                        ovf   <= pend_ovf | carry_out;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_iter.sv
// tb_bin2bcd_iter: self-checking bench for bin2bcd_iter. Two instances share
// the same stimulus, one with 5 digits and one with 4 digits (an overflow case).
// An arithmetic transaction model predicts busy/done/bcd/neg/ovf on every cycle.
module tb_bin2bcd_iter;

    localparam int W = 14;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] num;
    logic        sign_en;

    logic [19:0] dut5_bcd;
    logic        dut5_neg, dut5_ovf, dut5_busy, dut5_done;
    logic [15:0] dut4_bcd;
    logic        dut4_neg, dut4_ovf, dut4_busy, dut4_done;

    int checks = 0;
    int errors = 0;

    bin2bcd_iter #(.WIDTH(14), .DIGITS(5)) dut5 (
        .clk(clk), .rst(rst), .start(start), .num(num), .sign_en(sign_en),
        .bcd(dut5_bcd), .neg(dut5_neg), .ovf(dut5_ovf), .busy(dut5_busy), .done(dut5_done)
    );

    bin2bcd_iter #(.WIDTH(14), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .num(num), .sign_en(sign_en),
        .bcd(dut4_bcd), .neg(dut4_neg), .ovf(dut4_ovf), .busy(dut4_busy), .done(dut4_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: the magnitude of a 14-bit operand and its decimal digits.
    function automatic int unsigned magnitude(input logic [13:0] n, input logic s);
        if (s && n[13]) return 32'd16384 - 32'(n);
        return 32'(n);
    endfunction

    function automatic logic [19:0] to_bcd(input int unsigned v, input int digits);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Transaction model. An operand is accepted when idle. The result appears
    // W edges later together with a one-cycle done pulse.
    logic        m_busy, m_done, m_neg, m_ovf5, m_ovf4;
    logic        p_neg, p_ovf5, p_ovf4;
    logic [19:0] m_bcd5, p_bcd5;
    logic [15:0] m_bcd4, p_bcd4;
    int          m_left;

    always @(posedge clk) begin
        int unsigned v;
        if (rst) begin
            m_busy = 0; m_done = 0; m_left = 0;
            m_bcd5 = '0; m_bcd4 = '0; m_neg = 0; m_ovf5 = 0; m_ovf4 = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_bcd5 = p_bcd5; m_bcd4 = p_bcd4;
                    m_neg = p_neg; m_ovf5 = p_ovf5; m_ovf4 = p_ovf4;
                end
            end else if (start) begin
                v      = magnitude(num, sign_en);
                p_neg  = sign_en && num[13];
                p_bcd5 = to_bcd(v, 5);
                p_bcd4 = 16'(to_bcd(v, 4));
                p_ovf5 = v > 99999;
                p_ovf4 = v > 9999;
                m_busy = 1;
                m_left = W;
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("busy5", 32'(dut5_busy), 32'(m_busy));
            check("done5", 32'(dut5_done), 32'(m_done));
            check("bcd5",  32'(dut5_bcd),  32'(m_bcd5));
            check("neg5",  32'(dut5_neg),  32'(m_neg));
            check("ovf5",  32'(dut5_ovf),  32'(m_ovf5));
            check("busy4", 32'(dut4_busy), 32'(m_busy));
            check("done4", 32'(dut4_done), 32'(m_done));
            check("bcd4",  32'(dut4_bcd),  32'(m_bcd4));
            check("neg4",  32'(dut4_neg),  32'(m_neg));
            check("ovf4",  32'(dut4_ovf),  32'(m_ovf4));
        end
    end

    // Start one conversion and return the number of cycles from the accepting edge to done.
    task automatic convert(input logic [13:0] n, input logic s, output int lat);
        @(negedge clk);
        num = n; sign_en = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; num = 14'($urandom); sign_en = 1'($urandom);
        lat = 0;
        while (!dut5_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!dut5_done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, nb, nd, acc, seen;
        logic [19:0] got;
        logic [19:0] res [3];
        logic [13:0] picks [8];

        rst = 1'b1; start = 1'b0; num = '0; sign_en = 1'b0;
        picks = '{14'd0, 14'd1, 14'd9999, 14'd10000, 14'd8191, 14'd8192, 14'd16383, 14'd16382};

        // Pin the reference arithmetic to hand-computed values.
        check("pin_9999",  32'(to_bcd(magnitude(14'd9999, 1'b0), 5)), 32'h09999);
        check("pin_s3fff", 32'(to_bcd(magnitude(14'h3FFF, 1'b1), 5)), 32'h00001);
        check("pin_s2000", 32'(to_bcd(magnitude(14'h2000, 1'b1), 5)), 32'h08192);
        check("pin_d4",    32'(to_bcd(magnitude(14'd16383, 1'b0), 4)), 32'h06383);

        repeat (3) @(negedge clk);
        check("rst_bcd",  32'(dut5_bcd),  32'h0);
        check("rst_busy", 32'(dut5_busy), 32'h0);
        check("rst_done", 32'(dut5_done), 32'h0);
        rst = 1'b0;

        // Unsigned conversions.
        convert(14'd9999, 1'b0, lat);
        check("lat_9999", 32'(lat), 32'd14);
        check("bcd_9999", 32'(dut5_bcd), 32'h09999);
        check("neg_9999", 32'(dut5_neg), 32'h0);
        check("ovf_9999", 32'(dut5_ovf), 32'h0);
        check("d4_bcd_9999", 32'(dut4_bcd), 32'h9999);
        check("d4_ovf_9999", 32'(dut4_ovf), 32'h0);
        convert(14'd16383, 1'b0, lat);
        check("bcd_16383", 32'(dut5_bcd), 32'h16383);
        check("d4_bcd_16383", 32'(dut4_bcd), 32'h6383);
        check("d4_ovf_16383", 32'(dut4_ovf), 32'h1);
        convert(14'd0, 1'b0, lat);
        check("bcd_0", 32'(dut5_bcd), 32'h0);
        check("neg_0", 32'(dut5_neg), 32'h0);

        // Signed conversions.
        convert(14'h3FFF, 1'b1, lat);
        check("bcd_s3fff", 32'(dut5_bcd), 32'h00001);
        check("neg_s3fff", 32'(dut5_neg), 32'h1);
        convert(14'h2000, 1'b1, lat);
        check("bcd_s2000", 32'(dut5_bcd), 32'h08192);
        check("neg_s2000", 32'(dut5_neg), 32'h1);
        convert(14'h1FFF, 1'b1, lat);
        check("bcd_s1fff", 32'(dut5_bcd), 32'h08191);
        check("neg_s1fff", 32'(dut5_neg), 32'h0);
        convert(14'h3FFF, 1'b0, lat);
        check("bcd_u3fff", 32'(dut5_bcd), 32'h16383);
        check("neg_u3fff", 32'(dut5_neg), 32'h0);

        // A start during a conversion is ignored.
        @(negedge clk);
        num = 14'd1234; sign_en = 1'b0; start = 1'b1;
        @(negedge clk);
        nb = 0; nd = 0; got = '0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) begin start = 1'b1; num = 14'd4321; end
            else start = 1'b0;
            if (dut5_busy) nb++;
            if (dut5_done) begin nd++; got = dut5_bcd; end
            @(negedge clk);
        end
        start = 1'b0;
        check("hs_busy_cycles", 32'(nb), 32'd14);
        check("hs_done_count", 32'(nd), 32'd1);
        check("hs_bcd", 32'(got), 32'h01234);

        // Back-to-back conversions with start held high.
        num = 14'd1; sign_en = 1'b0; start = 1'b1;
        acc = 0; seen = 0;
        for (int t = 0; t < 200 && seen < 3; t++) begin
            @(negedge clk);
            if (m_busy && m_left == W) begin
                acc++;
                num = 14'(acc + 1);
                if (acc == 3) start = 1'b0;
            end
            if (dut5_done) begin res[seen] = dut5_bcd; seen++; end
        end
        start = 1'b0;
        check("b2b_count", 32'(seen), 32'd3);
        check("b2b_r0", 32'(res[0]), 32'h1);
        check("b2b_r1", 32'(res[1]), 32'h2);
        check("b2b_r2", 32'(res[2]), 32'h3);

        // Reset in the middle of a conversion.
        convert(14'd42, 1'b0, lat);
        check("bcd_42", 32'(dut5_bcd), 32'h00042);
        @(negedge clk);
        num = 14'd777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_bcd", 32'(dut5_bcd), 32'h0);
        check("abort_busy", 32'(dut5_busy), 32'h0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut5_done) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        convert(14'd5, 1'b0, lat);
        check("post_rst_lat", 32'(lat), 32'd14);
        check("post_rst_bcd", 32'(dut5_bcd), 32'h00005);

        // Reset wins over start on the same edge.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; num = 14'd100;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(dut5_busy), 32'h0);

        // Randomised traffic. The operand changes every cycle, start is mostly
        // high, and there are boundary values and rare resets.
        for (int i = 0; i < 36000; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 7) != 0);
            sign_en = 1'($urandom);
            if ($urandom_range(0, 3) == 0) num = picks[$urandom_range(0, 7)];
            else num = 14'($urandom);
            rst = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0; start = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
